lvds_rx_checker: RTL and testbench



---
 rtl/lvds_pkg.sv | 21 ++
 rtl/lvds_sat_cnt.sv | 31 +++
 rtl/lvds_rx_checker.sv | 163 ++++++++++++++++
 tb/tb_lvds_rx_checker.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_pkg.sv
// Shared definitions for the LVDS receive path: word width, comma symbols,
// checker state encoding and comma detection.
package lvds_pkg;

  localparam int WORD_W = 10;

  localparam logic [WORD_W-1:0] COMMA1 = 10'b01_0111_1100;
  localparam logic [WORD_W-1:0] COMMA2 = 10'b10_1000_0011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HUNT  = 2'd1,
    CHECK = 2'd2,
    TRAIL = 2'd3
  } rx_state_e;

  function automatic logic is_comma(input logic [WORD_W-1:0] word);
    return (word == COMMA1) || (word == COMMA2);
  endfunction

endpackage

// File: rtl/lvds_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear takes priority over
// increment and the count holds once it reaches MAX.
module lvds_sat_cnt #(
  parameter int unsigned   W   = 16,
  parameter logic [W-1:0]  MAX = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_r;

  // count register: clear beats increment, stop at MAX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (inc && (cnt_r != MAX)) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/lvds_rx_checker.sv
// Frame delimiter and incrementing-pattern checker for aligned LVDS words;
// counts word errors and reports link_ok after a run of clean frames.
module lvds_rx_checker
  import lvds_pkg::*;
#(
  parameter int FRAME_LEN   = 16,
  parameter int GOOD_FRAMES = 4
) (
  input  logic              rx_clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] rx_data,
  input  logic              align_done,
  input  logic              clr_err,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_done,
  output logic              frame_err,
  output logic [15:0]       err_cnt,
  output logic              link_ok
);

  localparam int               IDX_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [7:0]       RUN_LAST = 8'(GOOD_FRAMES - 1);

  rx_state_e         state_r, state_s;
  logic [IDX_W-1:0]  idx_r, idx_s;
  logic [WORD_W-1:0] exp_r, exp_s;
  logic              frame_bad_r, frame_bad_s;
  logic [WORD_W-1:0] data_out_s;
  logic              data_valid_s, frame_done_s, frame_err_s, link_ok_s;
  logic              comma_s, word_bad_s;
  logic              err_inc_s, run_inc_s, run_clr_s;
  logic [7:0]        good_run_r;

  // next-state, counter strobes and next output values
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    exp_s        = exp_r;
    frame_bad_s  = frame_bad_r;
    data_out_s   = data_out;
    data_valid_s = 1'b0;
    frame_done_s = 1'b0;
    frame_err_s  = 1'b0;
    link_ok_s    = link_ok;
    err_inc_s    = 1'b0;
    run_inc_s    = 1'b0;
    run_clr_s    = 1'b0;
    word_bad_s   = 1'b0;
    comma_s      = is_comma(rx_data);

    // losing alignment overrides everything, but err_cnt is kept
    if (!align_done) begin
      state_s   = IDLE;
      link_ok_s = 1'b0;
      run_clr_s = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = HUNT;
        end
        HUNT: begin
          if (comma_s) begin
            state_s     = CHECK;
            idx_s       = '0;
            exp_s       = '0;
            frame_bad_s = 1'b0;
          end else begin
            state_s = HUNT;
          end
        end
        CHECK: begin
          data_out_s   = rx_data;
          data_valid_s = 1'b1;
          word_bad_s   = comma_s || (rx_data != exp_r);
          err_inc_s    = word_bad_s;
          frame_bad_s  = frame_bad_r | word_bad_s;
          exp_s        = exp_r + WORD_W'(1);
          idx_s        = idx_r + IDX_W'(1);
          if (idx_r == LAST_IDX) begin
            state_s      = TRAIL;
            frame_done_s = 1'b1;
            if (frame_bad_s) begin
              frame_err_s = 1'b1;
              run_clr_s   = 1'b1;
              link_ok_s   = 1'b0;
            end else begin
              run_inc_s = 1'b1;
              link_ok_s = (good_run_r >= RUN_LAST) ? 1'b1 : link_ok;
            end
          end else begin
            state_s = CHECK;
          end
        end
        TRAIL: begin
          if (comma_s) begin
            state_s     = CHECK;
            idx_s       = '0;
            exp_s       = '0;
            frame_bad_s = 1'b0;
          end else begin
            state_s   = HUNT;
            err_inc_s = 1'b1;
            run_clr_s = 1'b1;
            link_ok_s = 1'b0;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // state, frame tracking and registered outputs
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      exp_r       <= '0;
      frame_bad_r <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      link_ok     <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      exp_r       <= exp_s;
      frame_bad_r <= frame_bad_s;
      data_out    <= data_out_s;
      data_valid  <= data_valid_s;
      frame_done  <= frame_done_s;
      frame_err   <= frame_err_s;
      link_ok     <= link_ok_s;
    end
  end

  lvds_sat_cnt #(
    .W   (16),
    .MAX (16'hFFFF)
  ) u_err_cnt (
    .clk (rx_clk),
    .rst (rst),
    .clr (clr_err),
    .inc (err_inc_s),
    .cnt (err_cnt)
  );

  lvds_sat_cnt #(
    .W   (8),
    .MAX (8'(GOOD_FRAMES))
  ) u_good_run (
    .clk (rx_clk),
    .rst (rst),
    .clr (run_clr_s),
    .inc (run_inc_s),
    .cnt (good_run_r)
  );

endmodule

// File: tb/tb_lvds_rx_checker.sv
// Scoreboard bench for lvds_rx_checker: a word-level reference model queues
// the expected outputs per cycle and a monitor compares them on the falling edge.
module tb_lvds_rx_checker;

  localparam int         FL    = 16;
  localparam int         GF    = 4;
  localparam logic [9:0] K_NEG = 10'h17C;
  localparam logic [9:0] K_POS = 10'h283;
  localparam logic [9:0] JUNK  = 10'h155;

  logic        rx_clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  rx_data = 10'd0;
  logic        align_done = 1'b0;
  logic        clr_err = 1'b0;
  logic [9:0]  data_out;
  logic        data_valid, frame_done, frame_err, link_ok;
  logic [15:0] err_cnt;

  logic        sat_clr = 1'b0;
  logic        sat_inc = 1'b0;
  logic [3:0]  sat_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int cyc;
    int dout;
    bit dv;
    bit fd;
    bit fe;
    bit lk;
    int err;
  } exp_t;

  exp_t sbq[$];

  // reference model: armed = past alignment, pos = -1 hunting,
  // 0..FL-1 next payload index, FL = comma due
  bit m_armed, m_bad, m_link;
  int m_pos, m_run, m_err, m_dout;

  always #5 rx_clk = ~rx_clk;
  always @(posedge rx_clk) cyc <= cyc + 1;

  lvds_rx_checker #(.FRAME_LEN(FL), .GOOD_FRAMES(GF)) dut (
    .rx_clk     (rx_clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .align_done (align_done),
    .clr_err    (clr_err),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .err_cnt    (err_cnt),
    .link_ok    (link_ok)
  );

  lvds_sat_cnt #(.W(4), .MAX(4'hF)) u_sat (
    .clk (rx_clk),
    .rst (rst),
    .clr (sat_clr),
    .inc (sat_inc),
    .cnt (sat_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_k(input logic [9:0] w);
    return (w == K_NEG) || (w == K_POS);
  endfunction

  task automatic model_reset();
    m_armed = 1'b0; m_bad = 1'b0; m_link = 1'b0;
    m_pos = -1; m_run = 0; m_err = 0; m_dout = 0;
  endtask

  task automatic bump_err();
    if (m_err < 65535) m_err++;
  endtask

  task automatic send(input logic [9:0] w, input bit ad, input bit clr);
    exp_t e;
    @(posedge rx_clk); #2;
    rx_data = w; align_done = ad; clr_err = clr;
    e.cyc = cyc + 1; e.dv = 1'b0; e.fd = 1'b0; e.fe = 1'b0;
    if (!ad) begin
      m_armed = 1'b0; m_pos = -1; m_run = 0; m_link = 1'b0;
    end else if (!m_armed) begin
      m_armed = 1'b1;
    end else if (m_pos < 0) begin
      if (is_k(w)) begin m_pos = 0; m_bad = 1'b0; end
    end else if (m_pos < FL) begin
      m_dout = int'(w); e.dv = 1'b1;
      if (is_k(w) || int'(w) != m_pos) begin bump_err(); m_bad = 1'b1; end
      m_pos++;
      if (m_pos == FL) begin
        e.fd = 1'b1;
        if (m_bad) begin
          e.fe = 1'b1; m_run = 0; m_link = 1'b0;
        end else begin
          m_run = (m_run < GF) ? m_run + 1 : GF;
          if (m_run == GF) m_link = 1'b1;
        end
      end
    end else begin
      if (is_k(w)) begin
        m_pos = 0; m_bad = 1'b0;
      end else begin
        bump_err(); m_run = 0; m_link = 1'b0; m_pos = -1;
      end
    end
    if (clr) m_err = 0;
    e.dout = m_dout; e.err = m_err; e.lk = m_link;
    sbq.push_back(e);
  endtask

  task automatic frame(input logic [9:0] k, input int bad_at, input logic [9:0] bad_val);
    send(k, 1'b1, 1'b0);
    for (int i = 0; i < FL; i++) send((i == bad_at) ? bad_val : 10'(i), 1'b1, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data_valid"}, int'(data_valid), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_frame_err"},  int'(frame_err),  0);
    chk({tag, "_link_ok"},    int'(link_ok),    0);
    chk({tag, "_err_cnt"},    int'(err_cnt),    0);
    chk({tag, "_data_out"},   int'(data_out),   0);
  endtask

  task automatic async_reset();
    @(posedge rx_clk); #6;
    align_done = 1'b0; clr_err = 1'b0; rx_data = 10'd0; rst = 1'b1;
    #1;
    chk_zero("async_rst");
    model_reset();
    @(posedge rx_clk); #2;
    rst = 1'b0;
  endtask

  // monitor: pop the entry due this cycle and compare every output
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge rx_clk);
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        vectors++; miscompares++;
        $display("FAIL stale_entry: got cycle %0d expected cycle %0d", cyc, sbq[0].cyc);
        void'(sbq.pop_front());
      end
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        e = sbq.pop_front();
        chk("data_valid", int'(data_valid), int'(e.dv));
        chk("frame_done", int'(frame_done), int'(e.fd));
        chk("frame_err",  int'(frame_err),  int'(e.fe));
        chk("link_ok",    int'(link_ok),    int'(e.lk));
        chk("err_cnt",    int'(err_cnt),    e.err);
        if (e.dv) chk("data_out", int'(data_out), e.dout);
      end
    end
  end

  initial begin : driver
    bit         drop;
    int         drop_at;
    logic [9:0] w;
    model_reset();
    repeat (3) @(posedge rx_clk);
    #1;
    chk_zero("reset");
    @(posedge rx_clk); #2;
    rst = 1'b0;

    // saturating counter holds at max, clear beats increment
    sat_inc = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge rx_clk); #1;
      chk("sat_count", int'(sat_cnt), (i < 15) ? i : 15);
    end
    sat_clr = 1'b1;
    @(posedge rx_clk); #1;
    chk("sat_clr_wins", int'(sat_cnt), 0);
    sat_clr = 1'b0; sat_inc = 1'b0;

    // clean frames up to link_ok
    send(JUNK, 1'b1, 1'b0);
    send(JUNK, 1'b1, 1'b0);
    repeat (4) frame(K_NEG, -1, 10'd0);
    // one corrupted word, then four clean frames to regain link
    frame(K_NEG, -1, 10'd0);
    frame(K_NEG, 5, 10'h3FF);
    repeat (4) frame(K_NEG, -1, 10'd0);
    // missing comma, recovery on the other polarity
    send(JUNK, 1'b1, 1'b0);
    frame(K_POS, -1, 10'd0);
    frame(K_POS, -1, 10'd0);
    // alignment lost mid-frame with link up
    repeat (4) frame(K_NEG, -1, 10'd0);
    send(K_NEG, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send(10'(i), 1'b1, 1'b0);
    send(10'd5, 1'b0, 1'b0);
    send(10'd6, 1'b0, 1'b0);
    send(JUNK, 1'b1, 1'b0);
    // clear coincident with a word error, errored last word, comma in payload
    send(K_POS, 1'b1, 1'b0);
    send(10'd0, 1'b1, 1'b0);
    send(10'h2AA, 1'b1, 1'b1);
    for (int i = 2; i < FL; i++) send(10'(i), 1'b1, 1'b0);
    frame(K_NEG, FL - 1, 10'd0);
    frame(K_POS, 3, K_NEG);
    // asynchronous reset mid-frame
    send(K_NEG, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) send(10'(i), 1'b1, 1'b0);
    async_reset();
    send(JUNK, 1'b1, 1'b0);

    // randomized stream
    for (int f = 0; f < 150; f++) begin
      if ($urandom_range(0, 99) < 8) send(10'($urandom), 1'b1, 1'b0);
      send(($urandom_range(0, 1) == 0) ? K_NEG : K_POS, 1'b1, $urandom_range(0, 49) == 0);
      drop_at = ($urandom_range(0, 49) == 0) ? int'($urandom_range(0, FL - 1)) : -1;
      drop = 1'b0;
      for (int i = 0; i < FL; i++) begin
        if (!drop) begin
          w = 10'(i);
          if ($urandom_range(0, 39) == 0) w = 10'($urandom);
          if (i == drop_at) begin
            send(w, 1'b0, 1'b0);
            send(w, 1'b0, 1'b0);
            send(JUNK, 1'b1, 1'b0);
            drop = 1'b1;
          end else begin
            send(w, 1'b1, $urandom_range(0, 49) == 0);
          end
        end
      end
    end

    repeat (3) @(negedge rx_clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
